// File: rtl/sum_array_loader.sv
// Stream-to-array loader for the prefix-sum kernel: fills a local buffer from a
// valid/ready stream, publishes the element count, and freezes until acknowledged.
module sum_array_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [31:0]       n_out,
    output logic              load_done,
    input  logic              kernel_ack,
    output logic              overflow
);

    typedef enum logic {S_FILL, S_DONE} state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [31:0]     DEPTH_N  = 32'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic              accept;
    logic              full_hit;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (accept && (in_last || full_hit)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (kernel_ack) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // in_ready is gated by reset so it reads 0 while reset is held, even though
    // the state register already sits in S_FILL.
    always_comb begin
        in_ready  = (state == S_FILL) && sys_rst_n;
        load_done = (state == S_DONE);
        accept    = in_valid && in_ready;
        full_hit  = (wr_ptr == LAST_IDX);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            n_out    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (in_last) begin
                n_out    <= 32'(wr_ptr) + 32'd1;
                overflow <= 1'b0;
            end else if (full_hit) begin
                n_out    <= DEPTH_N;
                overflow <= 1'b1;
            end
        end else if ((state == S_DONE) && kernel_ack) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end
    end

    // Buffer contents survive reset; only the pointer and flags are cleared.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_sum_array_loader.sv
// Randomized bench for sum_array_loader against an array/count reference model.
module tb_sum_array_loader;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] n_out;
    logic        load_done;
    logic        kernel_ack;
    logic        overflow;

    sum_array_loader #(.DATA_W(32), .DEPTH(256), .ADDR_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .n_out      (n_out),
        .load_done  (load_done),
        .kernel_ack (kernel_ack),
        .overflow   (overflow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model: buffer image, written-flags, element count, phase.
    logic [31:0] m_mem   [256];
    bit          m_known [256];
    int          m_wp;
    bit          m_fill;
    logic [31:0] m_n;
    bit          m_ovf;

    int n_cmp;
    int n_bad;
    logic [31:0] pkt[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        bit          acc;
        bit          rd_known;
        logic [31:0] exp_rd;
        acc      = in_valid && m_fill;
        rd_known = m_known[rd_addr];
        exp_rd   = m_mem[rd_addr];
        @(posedge sys_clk);
        if (acc) begin
            m_mem[m_wp]   = in_data;
            m_known[m_wp] = 1'b1;
            m_wp++;
            if (in_last) begin
                m_fill = 1'b0;
                m_n    = 32'(m_wp);
                m_ovf  = 1'b0;
            end else if (m_wp == 256) begin
                m_fill = 1'b0;
                m_n    = 32'd256;
                m_ovf  = 1'b1;
            end
        end else if (!m_fill && kernel_ack) begin
            m_fill = 1'b1;
            m_wp   = 0;
            m_ovf  = 1'b0;
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_fill));
        check("load_done", 32'(load_done), 32'(!m_fill));
        check("n_out", n_out, m_n);
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (rd_known) check("rd_data", rd_data, exp_rd);
    endtask

    task automatic do_reset();
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_n_out", n_out, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        m_fill = 1'b1;
        m_wp   = 0;
        m_n    = '0;
        m_ovf  = 1'b0;
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic rand_pkt(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back($urandom);
    endtask

    // Streams pkt, optionally resets after rst_after accepted beats, then sits in
    // the done phase for hold cycles before acknowledging.
    task automatic run_packet(input int len, input bit use_last, input int vpct,
                              input bit follow, input int rst_after, input int hold);
        int idx = 0;
        int cyc = 0;
        bit acc_now;
        while (m_fill && cyc < len * 4 + 64) begin
            if (rst_after >= 0 && idx == rst_after) begin
                in_valid = 1'b0;
                do_reset();
                return;
            end
            in_valid   = (idx < len) && ($urandom_range(99) < vpct);
            in_data    = (idx < len) ? pkt[idx] : $urandom;
            in_last    = use_last && (idx == len - 1);
            kernel_ack = ($urandom_range(9) == 0);
            rd_addr    = follow ? 8'(m_wp) : 8'($urandom);
            acc_now    = in_valid && m_fill;
            cycle();
            if (acc_now) idx++;
            cyc++;
        end
        kernel_ack = 1'b0;
        if (m_fill) begin
            check("load_done_timeout", 32'(load_done), 32'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            in_last  = 1'($urandom_range(1));
            rd_addr  = 8'((int'(m_n) - 1 + i) % int'(m_n));
            cycle();
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        kernel_ack = 1'b1;
        cycle();
        kernel_ack = 1'b0;
        cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        m_fill     = 1'b1;
        m_wp       = 0;
        m_n        = '0;
        m_ovf      = 1'b0;
        sys_rst_n  = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        rd_addr    = '0;
        kernel_ack = 1'b0;
        repeat (2) @(posedge sys_clk);
        do_reset();

        pkt = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        run_packet(5, 1'b1, 100, 1'b0, -1, 6);

        rand_pkt(4);
        run_packet(4, 1'b1, 50, 1'b0, -1, 10);

        rand_pkt(2);
        run_packet(2, 1'b1, 100, 1'b1, -1, 3);

        rand_pkt(300);
        run_packet(300, 1'b0, 100, 1'b0, -1, 5);

        rand_pkt(8);
        run_packet(8, 1'b1, 100, 1'b0, 3, 0);
        rand_pkt(3);
        run_packet(3, 1'b1, 100, 1'b0, -1, 4);

        pkt = {32'h11, 32'h22, 32'hAA, 32'h33};
        run_packet(4, 1'b1, 100, 1'b0, -1, 2);
        pkt = {32'h44, 32'h55, 32'hBB};
        run_packet(3, 1'b1, 100, 1'b1, -1, 3);

        rand_pkt(256);
        run_packet(256, 1'b1, 90, 1'b1, -1, 4);

        rand_pkt(1);
        run_packet(1, 1'b1, 100, 1'b0, -1, 2);

        for (int k = 0; k < 6; k++) begin
            int len;
            len = int'($urandom_range(1, 40));
            rand_pkt(len);
            run_packet(len, 1'b1, int'($urandom_range(30, 100)), 1'($urandom_range(1)), -1,
                       int'($urandom_range(1, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
